// File: rtl/bp_pkg.sv
// Shared branch-predictor types: default index widths, 2-bit counter encodings and the
// per-branch metadata record carried from fetch to retire.
package bp_pkg;

    localparam int unsigned PHT_IDX_W = 7;
    localparam int unsigned BHT_IDX_W = 4;

    typedef enum logic [1:0] {
        STRONGLY_NOT_TAKEN = 2'b00,
        WEAKLY_NOT_TAKEN   = 2'b01,
        WEAKLY_TAKEN       = 2'b10,
        STRONGLY_TAKEN     = 2'b11
    } bp_ctr_e;

    typedef struct packed {
        logic [PHT_IDX_W-1:0] pht_index;
        logic [BHT_IDX_W-1:0] bht_index;
        logic                 pred_taken;
    } bp_meta_t;

endpackage

// File: rtl/bp_meta_fifo.sv
// Circular buffer for branch metadata: unreset storage, wrapping pointers and an
// occupancy count that disambiguates full from empty.
module bp_meta_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data-only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/branch_update_queue.sv
// In-order queue of branch prediction metadata with registered PHT/BHT training strobes.
// Optional resolve/mispredict counters are built when BRANCH_UPDATE_QUEUE_STATS_EN is defined.
module branch_update_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PHT_IDX_W = bp_pkg::PHT_IDX_W,
    parameter int unsigned BHT_IDX_W = bp_pkg::BHT_IDX_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [PHT_IDX_W-1:0]     alloc_pht_index,
    input  logic [BHT_IDX_W-1:0]     alloc_bht_index,
    input  logic                     alloc_pred_taken,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    input  logic                     flush,
    output logic                     update_en,
    output logic [PHT_IDX_W-1:0]     update_PHT_index,
    output logic [BHT_IDX_W-1:0]     update_BHT_index,
    output logic                     branch_en,
    output logic                     mispredict,
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    output logic [31:0]              stat_resolved,
    output logic [31:0]              stat_mispred,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned META_W = PHT_IDX_W + BHT_IDX_W + 1;

    typedef struct packed {
        logic [PHT_IDX_W-1:0] pht_index;
        logic [BHT_IDX_W-1:0] bht_index;
        logic                 pred_taken;
    } meta_t;

    meta_t            alloc_meta, head_meta;
    logic [CNT_W-1:0] count;
    logic             push, pop, pop_mispred;

    logic                 update_en_q, update_en_d;
    logic                 mispredict_q, mispredict_d;
    logic                 branch_en_q, branch_en_d;
    logic [PHT_IDX_W-1:0] pht_q, pht_d;
    logic [BHT_IDX_W-1:0] bht_q, bht_d;

    // A flush drops any same-cycle allocation; the pop still completes.
    assign alloc_ready = (count != CNT_W'(DEPTH));
    assign push        = alloc_valid & alloc_ready & ~flush;
    assign pop         = resolve_valid & (count != '0);
    assign alloc_meta  = {alloc_pht_index, alloc_bht_index, alloc_pred_taken};
    assign pop_mispred = head_meta.pred_taken ^ resolve_taken;

    bp_meta_fifo #(
        .DEPTH (DEPTH),
        .W     (META_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (alloc_meta),
        .rdata_o (head_meta),
        .count_o (count)
    );

    always_comb begin
        update_en_d  = 1'b0;
        mispredict_d = 1'b0;
        branch_en_d  = branch_en_q;
        pht_d        = pht_q;
        bht_d        = bht_q;
        if (pop) begin
            update_en_d  = 1'b1;
            mispredict_d = pop_mispred;
            branch_en_d  = resolve_taken;
            pht_d        = head_meta.pht_index;
            bht_d        = head_meta.bht_index;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            update_en_q  <= 1'b0;
            mispredict_q <= 1'b0;
            branch_en_q  <= 1'b0;
            pht_q        <= '0;
            bht_q        <= '0;
        end else begin
            update_en_q  <= update_en_d;
            mispredict_q <= mispredict_d;
            branch_en_q  <= branch_en_d;
            pht_q        <= pht_d;
            bht_q        <= bht_d;
        end
    end

    assign update_en        = update_en_q;
    assign mispredict       = mispredict_q;
    assign branch_en        = branch_en_q;
    assign update_PHT_index = pht_q;
    assign update_BHT_index = bht_q;
    assign occupancy        = count;

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    logic [31:0] stat_resolved_q, stat_mispred_q;

    // Saturating event counters; deliberately unaffected by flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (pop && (stat_resolved_q != '1))
                stat_resolved_q <= stat_resolved_q + 32'd1;
            if (pop && pop_mispred && (stat_mispred_q != '1))
                stat_mispred_q <= stat_mispred_q + 32'd1;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: a vector table for single-cycle behaviour plus
// hand-written sequences for full-queue push/pop and asynchronous reset.
module tb_branch_update_queue;

    logic       clk = 1'b0;
    logic       resetn;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [6:0] alloc_pht_index;
    logic [3:0] alloc_bht_index;
    logic       alloc_pred_taken;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       flush;
    logic       update_en;
    logic [6:0] update_PHT_index;
    logic [3:0] update_BHT_index;
    logic       branch_en;
    logic       mispredict;
    logic [3:0] occupancy;
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_update_queue dut (
        .clk              (clk),
        .resetn           (resetn),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_pht_index  (alloc_pht_index),
        .alloc_bht_index  (alloc_bht_index),
        .alloc_pred_taken (alloc_pred_taken),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .flush            (flush),
        .update_en        (update_en),
        .update_PHT_index (update_PHT_index),
        .update_BHT_index (update_BHT_index),
        .branch_en        (branch_en),
        .mispredict       (mispredict),
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
        .stat_resolved    (stat_resolved),
        .stat_mispred     (stat_mispred),
`endif
        .occupancy        (occupancy)
    );

    typedef struct {
        logic       av;
        logic [6:0] pht;
        logic [3:0] bht;
        logic       pred;
        logic       rv;
        logic       rt;
        logic       fl;
        logic       rdy;
        logic [3:0] occ;
        logic       ue;
        logic [6:0] epht;
        logic [3:0] ebht;
        logic       ebr;
        logic       emp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic av, logic [6:0] pht, logic [3:0] bht, logic pred,
                                logic rv, logic rt, logic fl,
                                logic rdy, logic [3:0] occ, logic ue, logic [6:0] epht,
                                logic [3:0] ebht, logic ebr, logic emp);
        vec_t v;
        v.av = av; v.pht = pht; v.bht = bht; v.pred = pred;
        v.rv = rv; v.rt = rt; v.fl = fl;
        v.rdy = rdy; v.occ = occ; v.ue = ue; v.epht = epht;
        v.ebht = ebht; v.ebr = ebr; v.emp = emp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [6:0] pht, input logic [3:0] bht,
                         input logic pred, input logic rv, input logic rt, input logic fl);
        alloc_valid = av; alloc_pht_index = pht; alloc_bht_index = bht;
        alloc_pred_taken = pred; resolve_valid = rv; resolve_taken = rt; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        drive(0, 7'h0, 4'h0, 0, 0, 0, 0);

        // Test 1: single push then resolve
        vecs.push_back(mk(1, 7'h15, 4'h3, 1, 0, 0, 0,  1, 4'd1, 0, 7'h00, 4'h0, 0, 0));
        vecs.push_back(mk(0, 7'h00, 4'h0, 0, 1, 1, 0,  1, 4'd0, 1, 7'h15, 4'h3, 1, 0));
        // Test 4: resolve on empty is ignored, then normal push/pop
        vecs.push_back(mk(0, 7'h00, 4'h0, 0, 1, 0, 0,  1, 4'd0, 0, 7'h15, 4'h3, 1, 0));
        vecs.push_back(mk(1, 7'h0A, 4'h5, 0, 0, 0, 0,  1, 4'd1, 0, 7'h15, 4'h3, 1, 0));
        vecs.push_back(mk(0, 7'h00, 4'h0, 0, 1, 0, 0,  1, 4'd0, 1, 7'h0A, 4'h5, 0, 0));
        // Test 2: fill to 8, drop 9th, drain in order
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 7'(8'h20 + i), 4'(i), logic'(i % 2 == 1), 0, 0, 0,
                              logic'(i != 7), 4'(i + 1), 0, 7'h0A, 4'h5, 0, 0));
        vecs.push_back(mk(1, 7'h7F, 4'hF, 1, 0, 0, 0,  0, 4'd8, 0, 7'h0A, 4'h5, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 7'h00, 4'h0, 0, 1, 1, 0,
                              1, 4'(7 - i), 1, 7'(8'h20 + i), 4'(i), 1, logic'(i % 2 == 0)));
        // Test 5: flush with concurrent mispredicting pop and dropped push
        vecs.push_back(mk(1, 7'h11, 4'h1, 0, 0, 0, 0,  1, 4'd1, 0, 7'h27, 4'h7, 1, 0));
        vecs.push_back(mk(1, 7'h12, 4'h2, 1, 0, 0, 0,  1, 4'd2, 0, 7'h27, 4'h7, 1, 0));
        vecs.push_back(mk(1, 7'h13, 4'h3, 1, 0, 0, 0,  1, 4'd3, 0, 7'h27, 4'h7, 1, 0));
        vecs.push_back(mk(1, 7'h7E, 4'hE, 1, 1, 1, 1,  1, 4'd0, 1, 7'h11, 4'h1, 1, 1));
        vecs.push_back(mk(0, 7'h00, 4'h0, 0, 0, 0, 0,  1, 4'd0, 0, 7'h11, 4'h1, 1, 0));
        vecs.push_back(mk(1, 7'h30, 4'h6, 0, 0, 0, 0,  1, 4'd1, 0, 7'h11, 4'h1, 1, 0));
        vecs.push_back(mk(0, 7'h00, 4'h0, 0, 1, 0, 0,  1, 4'd0, 1, 7'h30, 4'h6, 0, 0));

        #12;
        chk("reset_ready", 32'(alloc_ready), 32'd1);
        chk("reset_occ",   32'(occupancy),   32'd0);
        chk("reset_ue",    32'(update_en),   32'd0);
        chk("reset_misp",  32'(mispredict),  32'd0);
        chk("reset_br",    32'(branch_en),   32'd0);
        chk("reset_pht",   32'(update_PHT_index), 32'd0);
        chk("reset_bht",   32'(update_BHT_index), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        foreach (vecs[k]) begin
            drive(vecs[k].av, vecs[k].pht, vecs[k].bht, vecs[k].pred,
                  vecs[k].rv, vecs[k].rt, vecs[k].fl);
            step();
            chk($sformatf("v%0d_ready", k), 32'(alloc_ready),      32'(vecs[k].rdy));
            chk($sformatf("v%0d_occ", k),   32'(occupancy),        32'(vecs[k].occ));
            chk($sformatf("v%0d_ue", k),    32'(update_en),        32'(vecs[k].ue));
            chk($sformatf("v%0d_pht", k),   32'(update_PHT_index), 32'(vecs[k].epht));
            chk($sformatf("v%0d_bht", k),   32'(update_BHT_index), 32'(vecs[k].ebht));
            chk($sformatf("v%0d_br", k),    32'(branch_en),        32'(vecs[k].ebr));
            chk($sformatf("v%0d_misp", k),  32'(mispredict),       32'(vecs[k].emp));
        end

        // Test 3: full queue, push+resolve same cycle pops only
        for (int i = 0; i < 8; i++) begin
            drive(1, 7'(8'h40 + i), 4'(i), 0, 0, 0, 0);
            step();
        end
        chk("t3_full_occ", 32'(occupancy), 32'd8);
        drive(1, 7'h4F, 4'hF, 0, 1, 0, 0);
        step();
        chk("t3_pp_occ",   32'(occupancy),        32'd7);
        chk("t3_pp_ready", 32'(alloc_ready),      32'd1);
        chk("t3_pp_ue",    32'(update_en),        32'd1);
        chk("t3_pp_pht",   32'(update_PHT_index), 32'h40);
        drive(1, 7'h4F, 4'hF, 0, 0, 0, 0);
        step();
        chk("t3_refill_occ",   32'(occupancy),   32'd8);
        chk("t3_refill_ready", 32'(alloc_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 7'h0, 4'h0, 0, 1, 0, 0);
            step();
            chk($sformatf("t3_drain%0d_pht", i), 32'(update_PHT_index),
                (i == 7) ? 32'h4F : 32'(8'h41 + i));
            chk($sformatf("t3_drain%0d_ue", i), 32'(update_en), 32'd1);
        end
        drive(0, 7'h0, 4'h0, 0, 0, 0, 0);
        step();
        chk("t3_empty_occ", 32'(occupancy), 32'd0);

        // Test 6: asynchronous reset with entries and a pending strobe
        for (int i = 0; i < 5; i++) begin
            drive(1, 7'(8'h50 + i), 4'(i), 1, 0, 0, 0);
            step();
        end
        drive(0, 7'h0, 4'h0, 0, 1, 1, 0);
        step();
        chk("t6_pre_ue",  32'(update_en), 32'd1);
        chk("t6_pre_occ", 32'(occupancy), 32'd4);
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
        chk("t6_pre_stat_res",  stat_resolved, 32'd22);
        chk("t6_pre_stat_misp", stat_mispred,  32'd5);
`endif
        drive(0, 7'h0, 4'h0, 0, 0, 0, 0);
        #3 resetn = 1'b0;
        #1;
        chk("t6_rst_occ",   32'(occupancy),        32'd0);
        chk("t6_rst_ue",    32'(update_en),        32'd0);
        chk("t6_rst_ready", 32'(alloc_ready),      32'd1);
        chk("t6_rst_pht",   32'(update_PHT_index), 32'd0);
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
        chk("t6_rst_stat_res",  stat_resolved, 32'd0);
        chk("t6_rst_stat_misp", stat_mispred,  32'd0);
`endif
        #2 resetn = 1'b1;
        drive(1, 7'h5A, 4'hA, 0, 0, 0, 0);
        step();
        chk("t6_post_occ", 32'(occupancy), 32'd1);
        drive(0, 7'h0, 4'h0, 0, 1, 1, 0);
        step();
        chk("t6_post_pht",  32'(update_PHT_index), 32'h5A);
        chk("t6_post_bht",  32'(update_BHT_index), 32'hA);
        chk("t6_post_misp", 32'(mispredict),       32'd1);
        drive(0, 7'h0, 4'h0, 0, 0, 0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
